// File: rtl/clock_divider_multi_if.sv
// Configuration port of clock_divider_multi: a valid/ready write channel
// carrying {channel, ratio, high time}, plus the per-channel pending flags.
interface clock_divider_multi_if #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 26,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch;
  logic [DIV_W-1:0]  cfg_div;
  logic [DIV_W-1:0]  cfg_high;
  logic [NUM_CH-1:0] cfg_pending;

  modport master (
    output cfg_valid, cfg_ch, cfg_div, cfg_high,
    input  cfg_ready, cfg_pending
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_div, cfg_high,
    output cfg_ready, cfg_pending
  );
endinterface

// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock/tick generator. Each channel divides clk
// by a runtime ratio D with high time H (low phase first) and emits a
// one-cycle tick on the last cycle of each period. New {D,H} pairs are held
// in a shadow register and only take effect at a period boundary, on
// disable, or on a global sync pulse, so out_clk never produces runt pulses.
module clock_divider_multi #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 26,
  parameter int DEFAULT_DIV = 50000,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CH-1:0]    ch_en,
  input  logic                 sync,
  clock_divider_multi_if.slave cfg,
  output logic [NUM_CH-1:0]    out_clk,
  output logic [NUM_CH-1:0]    tick
);

  localparam logic [DIV_W-1:0] DEF_DIV  = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] DEF_HIGH = DIV_W'(DEFAULT_DIV / 2);
  localparam logic [DIV_W-1:0] MIN_DIV  = DIV_W'(2);
  localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);
  localparam logic [DIV_W-1:0] ZERO     = DIV_W'(0);

  // Ratios below 2 cannot form a period with a distinct boundary.
  function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] div);
    if (div < MIN_DIV) begin
      return MIN_DIV;
    end else begin
      return div;
    end
  endfunction

  // High time is limited to the whole period (constant-high output).
  function automatic logic [DIV_W-1:0] eff_high(input logic [DIV_W-1:0] high,
                                                input logic [DIV_W-1:0] d);
    if (high > d) begin
      return d;
    end else begin
      return high;
    end
  endfunction

  logic [DIV_W-1:0]  cnt_r     [NUM_CH];
  logic [DIV_W-1:0]  div_r     [NUM_CH];
  logic [DIV_W-1:0]  high_r    [NUM_CH];
  logic [DIV_W-1:0]  sh_div_r  [NUM_CH];
  logic [DIV_W-1:0]  sh_high_r [NUM_CH];
  logic [NUM_CH-1:0] pending_r;
  logic [NUM_CH-1:0] out_clk_r;
  logic [NUM_CH-1:0] tick_r;

  logic [DIV_W-1:0]  d_s       [NUM_CH];
  logic [DIV_W-1:0]  h_s       [NUM_CH];
  logic [DIV_W-1:0]  low_len_s [NUM_CH];
  logic [NUM_CH-1:0] wrap_s;
  logic [NUM_CH-1:0] apply_s;
  logic [NUM_CH-1:0] sel_s;
  logic [NUM_CH-1:0] accept_s;
  logic              ch_valid_s;
  logic              ready_s;

  // Decode the target channel; out-of-range writes are always ready and dropped.
  always_comb begin
    sel_s      = '0;
    ch_valid_s = 1'b0;
    ready_s    = 1'b0;
    accept_s   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sel_s[i] = (cfg.cfg_ch == CH_W'(i));
    end
    ch_valid_s = |sel_s;
    if (!rst_n) begin
      ready_s = 1'b0;
    end else if (!ch_valid_s) begin
      ready_s = 1'b1;
    end else begin
      ready_s = ~|(pending_r & sel_s);
    end
    accept_s = sel_s & {NUM_CH{cfg.cfg_valid & ready_s}};
  end

  // Effective ratio/high time, period boundary and config-apply condition.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      d_s[i]       = eff_div(div_r[i]);
      h_s[i]       = eff_high(high_r[i], d_s[i]);
      low_len_s[i] = d_s[i] - h_s[i];
      wrap_s[i]    = (cnt_r[i] == (d_s[i] - ONE));
      apply_s[i]   = pending_r[i] & (~ch_en[i] | sync | wrap_s[i]);
    end
  end

  // Per-channel counter, shadow/active config and registered outputs.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (!rst_n) begin
        cnt_r[i]     <= ZERO;
        div_r[i]     <= DEF_DIV;
        high_r[i]    <= DEF_HIGH;
        sh_div_r[i]  <= ZERO;
        sh_high_r[i] <= ZERO;
        pending_r[i] <= 1'b0;
        out_clk_r[i] <= 1'b0;
        tick_r[i]    <= 1'b0;
      end else begin
        if (!ch_en[i]) begin
          cnt_r[i]     <= ZERO;
          out_clk_r[i] <= 1'b0;
          tick_r[i]    <= 1'b0;
        end else if (sync) begin
          // Restart at phase 0; the interrupted period gets no tick.
          cnt_r[i]     <= ZERO;
          out_clk_r[i] <= (cnt_r[i] >= low_len_s[i]);
          tick_r[i]    <= 1'b0;
        end else begin
          cnt_r[i]     <= wrap_s[i] ? ZERO : (cnt_r[i] + ONE);
          out_clk_r[i] <= (cnt_r[i] >= low_len_s[i]);
          tick_r[i]    <= wrap_s[i];
        end

        // Accept and apply are exclusive per channel: ready needs pending=0.
        if (apply_s[i]) begin
          div_r[i]     <= sh_div_r[i];
          high_r[i]    <= sh_high_r[i];
          pending_r[i] <= 1'b0;
        end else if (accept_s[i]) begin
          sh_div_r[i]  <= cfg.cfg_div;
          sh_high_r[i] <= cfg.cfg_high;
          pending_r[i] <= 1'b1;
        end else begin
          pending_r[i] <= pending_r[i];
        end
      end
    end
  end

  assign cfg.cfg_ready   = ready_s;
  assign cfg.cfg_pending = pending_r;
  assign out_clk         = out_clk_r;
  assign tick            = tick_r;

endmodule

// File: tb/tb_clock_divider_multi.sv
// Self-checking bench for clock_divider_multi. A cycle reference model
// pushes the expected {pending, out_clk, tick} for each edge into a queue
// as stimulus is applied; the entry is popped and compared after the edge.
// Directed checks pin the waveform shapes of the main scenarios.
module tb_clock_divider_multi;

  localparam int NCH  = 4;
  localparam int DW   = 26;
  localparam int DEFD = 8;

  logic clk;
  logic rst_n;
  logic [NCH-1:0] ch_en;
  logic sync;
  logic [NCH-1:0] out_clk;
  logic [NCH-1:0] tick;

  logic rst_n3;
  logic [2:0] ch_en3;
  logic sync3;
  logic [2:0] out_clk3;
  logic [2:0] tick3;

  clock_divider_multi_if #(.NUM_CH(NCH), .DIV_W(DW)) cif ();
  clock_divider_multi_if #(.NUM_CH(3), .DIV_W(DW)) cif3 ();

  clock_divider_multi #(.NUM_CH(NCH), .DIV_W(DW), .DEFAULT_DIV(DEFD)) dut (
    .clk(clk), .rst_n(rst_n), .ch_en(ch_en), .sync(sync),
    .cfg(cif), .out_clk(out_clk), .tick(tick)
  );

  clock_divider_multi #(.NUM_CH(3), .DIV_W(DW), .DEFAULT_DIV(4)) dut3 (
    .clk(clk), .rst_n(rst_n3), .ch_en(ch_en3), .sync(sync3),
    .cfg(cif3), .out_clk(out_clk3), .tick(tick3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [DW-1:0] m_cnt [NCH];
  logic [DW-1:0] m_div [NCH];
  logic [DW-1:0] m_high [NCH];
  logic [DW-1:0] m_sdiv [NCH];
  logic [DW-1:0] m_shigh [NCH];
  logic [NCH-1:0] m_pend;
  logic exp_ready;
  logic [11:0] exp_q [$];
  logic [31:0] hist_out [NCH];
  logic [31:0] hist_tick [NCH];

  task automatic model_step();
    logic [DW-1:0] d;
    logic [DW-1:0] h;
    logic wrap;
    logic acc;
    logic [NCH-1:0] o;
    logic [NCH-1:0] t;
    o = '0;
    t = '0;
    if (!rst_n) begin
      exp_ready = 1'b0;
      for (int i = 0; i < NCH; i++) begin
        m_cnt[i] = '0;
        m_div[i] = DW'(DEFD);
        m_high[i] = DW'(DEFD / 2);
        m_sdiv[i] = '0;
        m_shigh[i] = '0;
      end
      m_pend = '0;
    end else begin
      exp_ready = !m_pend[cif.cfg_ch];
      acc = cif.cfg_valid && exp_ready;
      for (int i = 0; i < NCH; i++) begin
        d = (m_div[i] < 26'd2) ? 26'd2 : m_div[i];
        h = (m_high[i] > d) ? d : m_high[i];
        wrap = (m_cnt[i] == d - 26'd1);
        if (!ch_en[i]) begin
          m_cnt[i] = '0;
        end else begin
          o[i] = (m_cnt[i] >= d - h);
          t[i] = wrap && !sync;
          m_cnt[i] = (sync || wrap) ? 26'd0 : m_cnt[i] + 26'd1;
        end
        if (m_pend[i] && (!ch_en[i] || sync || wrap)) begin
          m_div[i] = m_sdiv[i];
          m_high[i] = m_shigh[i];
          m_pend[i] = 1'b0;
        end else if (acc && int'(cif.cfg_ch) == i) begin
          m_sdiv[i] = cif.cfg_div;
          m_shigh[i] = cif.cfg_high;
          m_pend[i] = 1'b1;
        end
      end
    end
    exp_q.push_back({m_pend, o, t});
  endtask

  // One clock cycle: predict, check ready, take the edge, compare outputs.
  task automatic cyc();
    logic [11:0] e;
    #1;
    model_step();
    check("cfg_ready", 32'(cif.cfg_ready), 32'(exp_ready));
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("queue_empty", 32'(1), 32'(0));
    end else begin
      e = exp_q.pop_front();
      check("out_clk", 32'(out_clk), 32'(e[7:4]));
      check("tick", 32'(tick), 32'(e[3:0]));
      check("cfg_pending", 32'(cif.cfg_pending), 32'(e[11:8]));
    end
    for (int i = 0; i < NCH; i++) begin
      hist_out[i] = {hist_out[i][30:0], out_clk[i]};
      hist_tick[i] = {hist_tick[i][30:0], tick[i]};
    end
  endtask

  task automatic write_cfg(input int ch, input int div, input int high);
    cif.cfg_valid = 1'b1;
    cif.cfg_ch = 2'(ch);
    cif.cfg_div = DW'(div);
    cif.cfg_high = DW'(high);
    cyc();
    cif.cfg_valid = 1'b0;
  endtask

  task automatic wait_apply(input int ch);
    int n;
    n = 0;
    while (cif.cfg_pending[ch] && n < 40) begin
      cyc();
      n++;
    end
    check("apply_wait", 32'(cif.cfg_pending[ch]), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] h3o;
    logic [7:0] h3t;
    logic [7:0] h3o2;
    for (int i = 0; i < NCH; i++) begin
      hist_out[i] = '0;
      hist_tick[i] = '0;
    end
    rst_n = 1'b0;
    ch_en = 4'hF;
    sync = 1'b0;
    cif.cfg_valid = 1'b0;
    cif.cfg_ch = 2'd0;
    cif.cfg_div = '0;
    cif.cfg_high = '0;
    rst_n3 = 1'b0;
    ch_en3 = 3'b111;
    sync3 = 1'b0;
    cif3.cfg_valid = 1'b0;
    cif3.cfg_ch = 2'd0;
    cif3.cfg_div = '0;
    cif3.cfg_high = '0;

    // Reset and default ratio
    repeat (3) cyc();
    check("rst_out", 32'(out_clk), 32'(0));
    check("rst_tick", 32'(tick), 32'(0));
    rst_n = 1'b1;
    repeat (8) cyc();
    check("dflt_out0", 32'(hist_out[0][7:0]), 32'(8'b00001111));
    check("dflt_tick0", 32'(hist_tick[0][7:0]), 32'(8'b00000001));
    check("dflt_out3", 32'(hist_out[3][7:0]), 32'(8'b00001111));
    check("dflt_ready", 32'(cif.cfg_ready), 32'(1));

    // Boundary reload on ch0
    repeat (2) cyc();
    write_cfg(0, 5, 1);
    check("reload_pend", 32'(cif.cfg_pending[0]), 32'(1));
    check("reload_stall", 32'(cif.cfg_ready), 32'(0));
    repeat (4) cyc();
    check("reload_hold", 32'(cif.cfg_pending[0]), 32'(1));
    cyc();
    check("reload_applied", 32'(cif.cfg_pending[0]), 32'(0));
    repeat (5) cyc();
    check("reload_out0", 32'(hist_out[0][4:0]), 32'(5'b00001));
    check("reload_tick0", 32'(hist_tick[0][4:0]), 32'(5'b00001));

    // Clamping on ch1
    write_cfg(1, 1, 0);
    wait_apply(1);
    repeat (6) cyc();
    check("clamp_lo_out", 32'(hist_out[1][5:0]), 32'(6'b000000));
    check("clamp_lo_tick", 32'(hist_tick[1][5:0]), 32'(6'b010101));
    write_cfg(1, 6, 9);
    wait_apply(1);
    repeat (6) cyc();
    check("clamp_hi_out", 32'(hist_out[1][5:0]), 32'(6'b111111));
    check("clamp_hi_tick", 32'(hist_tick[1][5:0]), 32'(6'b000001));

    // Sync alignment: ch1/ch2 D=6 offset by 3, pending write on ch3
    write_cfg(1, 6, 3);
    wait_apply(1);
    write_cfg(2, 6, 3);
    wait_apply(2);
    ch_en = 4'b1001;
    cyc();
    ch_en = 4'b1011;
    repeat (3) cyc();
    ch_en = 4'b1111;
    n = 0;
    cyc();
    while (!tick[3] && n < 20) begin
      cyc();
      n++;
    end
    check("tick3_seen", 32'(tick[3]), 32'(1));
    write_cfg(3, 4, 2);
    check("sync_pend3", 32'(cif.cfg_pending[3]), 32'(1));
    sync = 1'b1;
    cyc();
    sync = 1'b0;
    check("sync_applied3", 32'(cif.cfg_pending[3]), 32'(0));
    check("sync_no_tick", 32'(tick), 32'(0));
    repeat (12) cyc();
    check("sync_out1", 32'(hist_out[1][11:0]), 32'(12'b000111000111));
    check("sync_out2", 32'(hist_out[2][11:0]), 32'(12'b000111000111));
    check("sync_tick2", 32'(hist_tick[2][11:0]), 32'(12'b000001000001));
    check("sync_out3", 32'(hist_out[3][11:0]), 32'(12'b001100110011));
    check("sync_tick3", 32'(hist_tick[3][11:0]), 32'(12'b000100010001));

    // Disable ch2 at cnt=3 with a pending write, then re-enable
    write_cfg(2, 4, 1);
    repeat (2) cyc();
    check("dis_pend2", 32'(cif.cfg_pending[2]), 32'(1));
    ch_en = 4'b1011;
    cyc();
    check("dis_out2", 32'(out_clk[2]), 32'(0));
    check("dis_tick2", 32'(tick[2]), 32'(0));
    check("dis_applied2", 32'(cif.cfg_pending[2]), 32'(0));
    cyc();
    ch_en = 4'b1111;
    repeat (4) cyc();
    check("reen_out2", 32'(hist_out[2][3:0]), 32'(4'b0001));
    check("reen_tick2", 32'(hist_tick[2][3:0]), 32'(4'b0001));

    // Reset in the middle of operation with a pending write
    write_cfg(0, 7, 3);
    check("mid_pend0", 32'(cif.cfg_pending[0]), 32'(1));
    rst_n = 1'b0;
    cyc();
    check("mid_rst_out", 32'(out_clk), 32'(0));
    check("mid_rst_tick", 32'(tick), 32'(0));
    check("mid_rst_pend", 32'(cif.cfg_pending), 32'(0));
    rst_n = 1'b1;
    repeat (8) cyc();
    check("mid_rst_dflt", 32'(hist_out[0][7:0]), 32'(8'b00001111));

    // Back-to-back writes to ch0: second stalls until the first applies
    write_cfg(0, 3, 1);
    cif.cfg_valid = 1'b1;
    cif.cfg_ch = 2'd0;
    cif.cfg_div = DW'(4);
    cif.cfg_high = DW'(2);
    #1;
    check("b2b_stall", 32'(cif.cfg_ready), 32'(0));
    n = 0;
    while (!cif.cfg_ready && n < 20) begin
      cyc();
      n++;
    end
    check("b2b_stall_len", 32'(n), 32'(7));
    cyc();
    cif.cfg_valid = 1'b0;
    check("b2b_pend", 32'(cif.cfg_pending[0]), 32'(1));
    wait_apply(0);
    repeat (8) cyc();
    check("b2b_out0", 32'(hist_out[0][7:0]), 32'(8'b00110011));

    // Out-of-range channel on a 3-channel instance
    check("inv_rst_out", 32'(out_clk3), 32'(0));
    rst_n3 = 1'b1;
    cif3.cfg_valid = 1'b1;
    cif3.cfg_ch = 2'd3;
    cif3.cfg_div = DW'(2);
    cif3.cfg_high = DW'(0);
    #1;
    check("inv_ready", 32'(cif3.cfg_ready), 32'(1));
    h3o = '0;
    h3t = '0;
    h3o2 = '0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      cif3.cfg_valid = 1'b0;
      check("inv_pend", 32'(cif3.cfg_pending), 32'(0));
      h3o = {h3o[6:0], out_clk3[0]};
      h3t = {h3t[6:0], tick3[0]};
      h3o2 = {h3o2[6:0], out_clk3[2]};
    end
    check("inv_out0", 32'(h3o), 32'(8'b00110011));
    check("inv_tick0", 32'(h3t), 32'(8'b00010001));
    check("inv_out2", 32'(h3o2), 32'(8'b00110011));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
